// File: rtl/pkt_rr_port_sched.sv
// Packet-aware round-robin output-port scheduler with wormhole locking.
// Optional starvation monitor enabled by defining PKT_RR_PORT_SCHED_STARVE_MON_EN.
module pkt_rr_port_sched #(
    parameter int N_REQ        = 4,
    parameter int CNT_W        = 5,
    parameter int STARVE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_tail,
    output logic [N_REQ-1:0] req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_REQ-1:0] out_sel,
    output logic             out_tail,
    output logic             busy,
    output logic [N_REQ-1:0] starve
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next, owner_idx;
    logic [N_REQ-1:0] owner, owner_next;
    logic [N_REQ-1:0] masked, winner;
    logic             locked;

    // Thermometer mask keeps requesters at or above ptr; fall back to the full set on wrap.
    always_comb begin
        masked = req_valid & ~((N_REQ'(1) << ptr) - N_REQ'(1));
        if (|masked) begin
            winner = masked & (~masked + N_REQ'(1));
        end else begin
            winner = req_valid & (~req_valid + N_REQ'(1));
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner[i]) begin
                owner_idx = IDX_W'(i);
            end
        end
    end

    assign locked = (state == LOCKED);

    always_comb begin
        out_sel   = locked ? owner : '0;
        busy      = locked;
        out_valid = locked & |(req_valid & owner);
        out_tail  = locked & |(req_valid & req_tail & owner);
        req_ready = (locked && out_ready) ? owner : '0;
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    owner_next = winner;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (out_valid && out_ready && out_tail) begin
                    state_next = IDLE;
                    owner_next = '0;
                    ptr_next   = (owner_idx == IDX_W'(N_REQ - 1)) ? '0 : owner_idx + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                owner_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
        end
    end

`ifdef PKT_RR_PORT_SCHED_STARVE_MON_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    // Saturating wait counters; owner is only non-zero while locked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || owner[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != {CNT_W{1'b1}}) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starve[i] = (cnt[i] >= CNT_W'(STARVE_LIMIT));
        end
    end
`else
    assign starve = '0;
`endif

endmodule
